// File: rtl/sw_irq_pkg.sv
// Shared constants for the switch interrupt controller: interrupt line index and channel limit.
// No timing or flow control of its own.
package sw_irq_pkg;
    localparam int INT_LINE = 0;
    localparam int MAX_SW   = 32;
endpackage

// File: rtl/sw_debounce.sv
// One switch channel: synchroniser, stability counter, accepted level and combinational edge pulses.
// Level moves SYNC_STAGES+DEB_CYCLES-1 edges after the first sampling edge; free-running, no backpressure.
module sw_debounce
    import sw_irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 1000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_q, level_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   sync;
    logic                   fire;

    always_comb begin
        sync    = sync_q[SYNC_STAGES-1];
        fire    = (sync != level_q) && (cnt_q == CW'(DEB_CYCLES - 1));
        level_d = level_q;
        cnt_d   = cnt_q + CW'(1);
        if (sync == level_q) begin
            cnt_d = '0;
        end else if (fire) begin
            level_d = sync;
            cnt_d   = '0;
        end
        // Pulses are valid on the same edge that commits the new level.
        rise_o  = fire & sync;
        fall_o  = fire & ~sync;
        level_o = level_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/sw_irq_ctrl.sv
// Debounced switch bank with per-channel edge select, sticky pending bits and a masked interrupt request.
// Pending updates on the edge that accepts a new level; int_req follows combinationally; no backpressure.
module sw_irq_ctrl
    import sw_irq_pkg::*;
#(
    parameter int NUM_SW      = 16,
    parameter int DEB_CYCLES  = 1000,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_SW-1:0] in_i,
    input  logic [NUM_SW-1:0] rise_en_i,
    input  logic [NUM_SW-1:0] fall_en_i,
    input  logic [NUM_SW-1:0] mask_i,
    output logic [31:0]       out_o,
    output logic [31:0]       pending_o,
    output logic [31:0]       int_req_o,
    input  logic [31:0]       int_fin_i
);
    logic [NUM_SW-1:0] level, rise, fall, ev;
    logic [NUM_SW-1:0] pending_q, pending_d;
    logic [MAX_SW-1:0] unused_fin;

    assign unused_fin = int_fin_i;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
        sw_debounce #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .raw_i  (in_i[i]),
            .level_o(level[i]),
            .rise_o (rise[i]),
            .fall_o (fall[i])
        );
    end

    always_comb begin
        ev = (rise & rise_en_i) | (fall & fall_en_i);
        // OR-ing ev after the clear keeps an event that coincides with the acknowledge.
        pending_d = (int_fin_i[INT_LINE] ? '0 : pending_q) | ev;
        out_o                = '0;
        out_o[NUM_SW-1:0]    = level;
        pending_o            = '0;
        pending_o[NUM_SW-1:0] = pending_q;
        int_req_o            = '0;
        int_req_o[INT_LINE]  = |(pending_q & mask_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end
endmodule
